mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of Busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of Busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data1  input  32  rs operand (same EX-stage operand as the ALU's data1).
REQ-006 SHALL have port data2  input  32  rt operand (same EX-stage operand as the ALU's data2).
REQ-007 SHALL have port MDOp  input  3  operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-008 SHALL have port Start  input  1  qualifies MDOp for one cycle.
REQ-009 SHALL have port Busy  output  1  registered; high while an operation is in flight.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL accept an operation only on a rising edge where Start=1, Busy=0 and MDOp is not none (accept edge T0).
REQ-013 SHALL ignore Start and all MDOp values while Busy=1; HI, LO and the in-flight operation are not disturbed.
REQ-014 SHALL on accepting mult/multu/div/divu compute the 64-bit result from data1/data2 sampled at T0 into internal pending registers, load the countdown with MULT_CYCLES or DIV_CYCLES, and set Busy=1 from T0+1.
REQ-015 SHALL decrement the countdown on each edge; on the edge where it reaches 0, write pending to HI/LO and clear Busy, so Busy is high for exactly N cycles and the new HI/LO are visible in the same cycle Busy first reads 0.
REQ-016 SHALL implement mult as a signed 32x32 product and multu as an unsigned 32x32 product: HI = product[63:32], LO = product[31:0].
REQ-017 SHALL implement div/divu with LO = quotient and HI = remainder; signed quotient truncates toward zero, and the remainder takes the sign of the dividend (data1).
REQ-018 SHALL on signed 0x80000000 / 0xFFFFFFFF produce LO = 0x80000000 and HI = 0x00000000.
REQ-019 SHALL on a divisor of 0 (div or divu) still assert Busy for DIV_CYCLES but leave HI and LO unchanged at completion.
REQ-020 SHALL on accepting mthi/mtlo write data1 to HI/LO respectively at edge T0 with no Busy cycle; the other register is unchanged.
REQ-021 SHALL allow a new Start on the first cycle Busy reads 0 (back-to-back operations with no idle cycle).

Reset
REQ-022 SHALL on reset=0, asynchronously and independent of clk, clear HI, LO, pending registers, countdown and Busy to 0.
REQ-023 SHALL on reset asserted mid-operation discard the in-flight result; HI/LO read 0 after reset release.
REQ-024 SHALL accept a new operation on the first rising edge after reset deasserts.

Structure
REQ-025 SHALL take the MDOp encodings, MULT_CYCLES and DIV_CYCLES defaults from the shared CPU definitions package, which also holds the ALUOp encodings.
REQ-026 SHALL be a single module with no sub-modules; the countdown and pending registers are local; the operation state is IDLE (countdown=0) or RUN (countdown>0).

Verification
REQ-027 SHALL cover: mult, data1=0xFFFFFFFE (-2), data2=3 -> Busy high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-028 SHALL cover: multu, 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE and LO=0x00000001 after 5 cycles.
REQ-029 SHALL cover: div, -7/2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF after 10 Busy cycles; divu, 7/0 with HI/LO preloaded via mthi/mtlo as 0x11 and 0x22 -> both unchanged after 10 cycles.
REQ-030 SHALL cover: Start with mtlo 0x5 while a div is busy -> ignored, so LO equals the div quotient at completion.
REQ-031 SHALL cover: reset pulsed low at Busy cycle 3 of a mult -> Busy, HI and LO are 0 immediately, and no late write occurs.
REQ-032 SHALL cover: a second mult started in the first cycle Busy=0 -> accepted, with Busy high for 5 more cycles.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ALU and multiply/divide operation encodings,
// multiply/divide latencies and the multiply/divide sequencer states.
package cpu_defs_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_NOP7  = 3'b111
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Operations that occupy the unit for a countdown rather than completing at once.
  function automatic logic isLongOp(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isValidOp(input md_op_e op);
    return (op != MD_NONE) && (op != MD_NOP7);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers: the result is
// computed at accept time, held as pending, and committed when the countdown ends.
module mult_div_unit
  import cpu_defs_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pendHi_q, pendLo_q;
  logic             pendValid_q;

  md_op_e           op;
  logic             accept;
  logic [63:0]      result_d;
  logic             resValid_d;
  logic [CNT_W-1:0] load_d;

  logic signed [63:0] sProd;
  logic [63:0]        uProd;
  logic signed [31:0] sA, sB, sQuot, sRem;

  assign op     = md_op_e'(MDOp);
  assign accept = Start && (state_q == MD_IDLE) && isValidOp(op);

  assign sA    = $signed(data1);
  assign sB    = $signed(data2);
  assign sProd = $signed({{32{data1[31]}}, data1}) * $signed({{32{data2[31]}}, data2});
  assign uProd = {32'b0, data1} * {32'b0, data2};

  // Result is {HI, LO}; a zero divisor leaves resValid_d low so HI/LO survive.
  always_comb begin
    result_d   = '0;
    resValid_d = 1'b0;
    load_d     = '0;
    sQuot      = '0;
    sRem       = '0;
    case (op)
      MD_MULT: begin
        result_d   = sProd;
        resValid_d = 1'b1;
        load_d     = CNT_W'(MULT_CYCLES);
      end
      MD_MULTU: begin
        result_d   = uProd;
        resValid_d = 1'b1;
        load_d     = CNT_W'(MULT_CYCLES);
      end
      MD_DIV: begin
        load_d = CNT_W'(DIV_CYCLES);
        if (data2 != 32'd0) begin
          resValid_d = 1'b1;
          if ((data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF)) begin
            result_d = {32'h0000_0000, 32'h8000_0000};
          end else begin
            sQuot    = sA / sB;
            sRem     = sA % sB;
            result_d = {sRem, sQuot};
          end
        end
      end
      MD_DIVU: begin
        load_d = CNT_W'(DIV_CYCLES);
        if (data2 != 32'd0) begin
          resValid_d = 1'b1;
          result_d   = {data1 % data2, data1 / data2};
        end
      end
      default: begin
        result_d   = '0;
        resValid_d = 1'b0;
        load_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MD_IDLE;
      count_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pendHi_q    <= '0;
      pendLo_q    <= '0;
      pendValid_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            if (op == MD_MTHI) begin
              hi_q <= data1;
            end else if (op == MD_MTLO) begin
              lo_q <= data1;
            end else begin
              pendHi_q    <= result_d[63:32];
              pendLo_q    <= result_d[31:0];
              pendValid_q <= resValid_d;
              count_q     <= load_d;
              state_q     <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_q <= MD_IDLE;
            if (pendValid_q) begin
              hi_q <= pendHi_q;
              lo_q <= pendLo_q;
            end
          end
        end
        default: begin
          state_q <= MD_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign Busy = (state_q == MD_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed corner cases plus random operations,
// checked against an arithmetic model of HI/LO and the expected Busy length.
module tb_mult_div_unit;
  import cpu_defs_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data1, data2;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] mdlHi = 32'd0;
  logic [31:0] mdlLo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .data1(data1), .data2(data2),
    .MDOp(MDOp), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Architectural model: plain 64-bit arithmetic; returns how long Busy should stay high.
  task automatic modelApply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     v;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = longint'(a);
    ub = longint'(b);
    n  = 0;
    case (op)
      3'd1: begin v = sa * sb; mdlHi = v[63:32]; mdlLo = v[31:0]; n = MULT_N; end
      3'd2: begin v = ua * ub; mdlHi = v[63:32]; mdlLo = v[31:0]; n = MULT_N; end
      3'd3: begin
        n = DIV_N;
        if (b != 32'd0) begin
          v = sa / sb; mdlLo = v[31:0];
          v = sa % sb; mdlHi = v[31:0];
        end
      end
      3'd4: begin
        n = DIV_N;
        if (b != 32'd0) begin
          v = ua / ub; mdlLo = v[31:0];
          v = ua % ub; mdlHi = v[31:0];
        end
      end
      3'd5: mdlHi = a;
      3'd6: mdlLo = a;
      default: n = 0;
    endcase
  endtask

  // Called right after a falling edge; the next rising edge is the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp  = op;
    data1 = a;
    data2 = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    data1 = $urandom;
    data2 = $urandom;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int expN, gotN;
    modelApply(op, a, b, expN);
    applyStimulus(op, a, b);
    waitDone(gotN);
    checkOutput({tag, " busy cycles"}, 32'(gotN), 32'(expN));
    checkOutput({tag, " HI"}, HI, mdlHi);
    checkOutput({tag, " LO"}, LO, mdlLo);
  endtask

  initial begin
    int          expN, gotN;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b0;
    Start = 1'b0;
    MDOp  = 3'd0;
    data1 = '0;
    data2 = '0;
    #12;
    checkOutput("reset Busy", {31'b0, Busy}, 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3);
    runOp("multu max*max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    runOp("mthi 0x11", MD_MTHI, 32'h11, 32'd0);
    runOp("mtlo 0x22", MD_MTLO, 32'h22, 32'd0);
    runOp("divu 7/0", MD_DIVU, 32'd7, 32'd0);
    runOp("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE);
    runOp("div minint/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("div 5/0", MD_DIV, 32'd5, 32'd0);
    runOp("none op7", MD_NOP7, 32'h1234, 32'd1);

    // mtlo arriving while a divide is busy must be dropped
    modelApply(MD_DIV, 32'd100, 32'd7, expN);
    applyStimulus(MD_DIV, 32'd100, 32'd7);
    MDOp  = MD_MTLO;
    data1 = 32'h5;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    waitDone(gotN);
    checkOutput("ignored mtlo busy cycles", 32'(gotN + 1), 32'(expN));
    checkOutput("ignored mtlo LO", LO, mdlLo);
    checkOutput("ignored mtlo HI", HI, mdlHi);

    // Reset in the middle of a multiply
    runOp("preload mthi", MD_MTHI, 32'hAAAA_0000, 32'd0);
    runOp("preload mtlo", MD_MTLO, 32'h0000_5555, 32'd0);
    applyStimulus(MD_MULT, 32'd123, 32'd456);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    mdlHi = 32'd0;
    mdlLo = 32'd0;
    checkOutput("async reset Busy", {31'b0, Busy}, 32'd0);
    checkOutput("async reset HI", HI, 32'd0);
    checkOutput("async reset LO", LO, 32'd0);
    @(negedge clk);
    MDOp  = MD_MTLO;
    data1 = 32'h77;
    Start = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    mdlLo = 32'h77;
    checkOutput("first edge after reset LO", LO, mdlLo);
    repeat (8) @(negedge clk);
    checkOutput("no late write Busy", {31'b0, Busy}, 32'd0);
    checkOutput("no late write HI", HI, mdlHi);
    checkOutput("no late write LO", LO, mdlLo);

    // Back-to-back: runOp returns on the first Busy=0 cycle and the next starts there
    runOp("b2b mult 1", MD_MULT, 32'd1000, 32'hFFFF_FF00);
    runOp("b2b mult 2", MD_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      runOp($sformatf("random %0d op%0d", i, rop), rop, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
